// File: rtl/axi4_master_arbiter_pkg.sv
// Shared types for the two-requester AXI4-Lite master arbiter: FSM encoding
// and AXI response codes.
package axi4_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } arb_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi4_master_arbiter_if.sv
// Single-beat AXI4-Lite bus (AW/W/B/AR/R, no burst/ID/strobe) between the
// arbiter (master) and the interconnect (slave).
interface axi4_master_arbiter_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) ();
  logic [AXI_ADDR_WIDTH-1:0] AXI_AWADDR;
  logic                      AXI_AWVALID;
  logic                      AXI_AWREADY;
  logic [AXI_DATA_WIDTH-1:0] AXI_WDATA;
  logic                      AXI_WVALID;
  logic                      AXI_WREADY;
  logic [1:0]                AXI_BRESP;
  logic                      AXI_BVALID;
  logic                      AXI_BREADY;
  logic [AXI_ADDR_WIDTH-1:0] AXI_ARADDR;
  logic                      AXI_ARVALID;
  logic                      AXI_ARREADY;
  logic [AXI_DATA_WIDTH-1:0] AXI_RDATA;
  logic                      AXI_RVALID;
  logic [1:0]                AXI_RRESP;
  logic                      AXI_RREADY;

  modport master (
    output AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WVALID, AXI_BREADY,
           AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
    input  AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID,
           AXI_ARREADY, AXI_RDATA, AXI_RVALID, AXI_RRESP
  );

  modport slave (
    input  AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WVALID, AXI_BREADY,
           AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
    output AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID,
           AXI_ARREADY, AXI_RDATA, AXI_RVALID, AXI_RRESP
  );
endinterface

// File: rtl/axi4_master_arbiter_rr_arbiter_2.sv
// Two-way round-robin pick: on contention the requester that did not win
// last time gets the one-hot grant; otherwise the sole requester wins.
module rr_arbiter_2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = last_grant_i ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/axi4_master_arbiter.sv
// Shares one AXI4-Lite master port between two register requesters, one
// transaction at a time, with round-robin grant and per-requester results.
module axi4_master_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      REQ0_VALID,
  input  logic                      REQ0_WRITE,
  input  logic [AXI_ADDR_WIDTH-1:0] REQ0_ADDR,
  input  logic [AXI_DATA_WIDTH-1:0] REQ0_WDATA,
  output logic                      REQ0_READY,
  output logic                      REQ0_DONE,
  output logic [AXI_DATA_WIDTH-1:0] REQ0_RDATA,
  output logic [1:0]                REQ0_RESP,
  input  logic                      REQ1_VALID,
  input  logic                      REQ1_WRITE,
  input  logic [AXI_ADDR_WIDTH-1:0] REQ1_ADDR,
  input  logic [AXI_DATA_WIDTH-1:0] REQ1_WDATA,
  output logic                      REQ1_READY,
  output logic                      REQ1_DONE,
  output logic [AXI_DATA_WIDTH-1:0] REQ1_RDATA,
  output logic [1:0]                REQ1_RESP,
  axi4_master_arbiter_if.master     axi
);
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;

  arb_state_e          state_q;
  logic                last_grant_q, cur_q;
  logic [1:0]          req_vld, gnt, ready_q, done_q;
  logic [1:0][DW-1:0]  rdata_q;
  logic [1:0][1:0]     resp_q;
  logic [AW-1:0]       awaddr_q, araddr_q, sel_addr;
  logic [DW-1:0]       wdata_q, sel_wdata;
  logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                gnt_idx, sel_write, aw_open, w_open;

  assign req_vld = {REQ1_VALID, REQ0_VALID};

  rr_arbiter_2 u_rr (
    .req_i       (req_vld),
    .last_grant_i(last_grant_q),
    .gnt_o       (gnt)
  );

  assign gnt_idx   = gnt[1];
  assign sel_write = gnt_idx ? REQ1_WRITE : REQ0_WRITE;
  assign sel_addr  = gnt_idx ? REQ1_ADDR  : REQ0_ADDR;
  assign sel_wdata = gnt_idx ? REQ1_WDATA : REQ0_WDATA;

  // Channel still waiting after this edge; AW and W retire independently.
  assign aw_open = awvalid_q & ~axi.AXI_AWREADY;
  assign w_open  = wvalid_q  & ~axi.AXI_WREADY;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cur_q        <= 1'b0;
      ready_q      <= '0;
      done_q       <= '0;
      rdata_q      <= '0;
      resp_q       <= '0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      araddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
    end else begin
      ready_q <= '0;
      done_q  <= '0;
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            ready_q      <= gnt;
            last_grant_q <= gnt_idx;
            cur_q        <= gnt_idx;
            if (sel_write) begin
              awaddr_q  <= sel_addr;
              wdata_q   <= sel_wdata;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_ADDR_DATA;
            end else begin
              araddr_q  <= sel_addr;
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (!aw_open) awvalid_q <= 1'b0;
          if (!w_open)  wvalid_q  <= 1'b0;
          // An early BVALID is ignored until both address and data are out.
          if (!aw_open && !w_open) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.AXI_BVALID) begin
            bready_q       <= 1'b0;
            done_q[cur_q]  <= 1'b1;
            resp_q[cur_q]  <= axi.AXI_BRESP;
            state_q        <= IDLE;
          end
        end
        RD_ADDR: begin
          if (axi.AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi.AXI_RVALID) begin
            rready_q       <= 1'b0;
            done_q[cur_q]  <= 1'b1;
            rdata_q[cur_q] <= axi.AXI_RDATA;
            resp_q[cur_q]  <= axi.AXI_RRESP;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REQ0_READY = ready_q[0];
  assign REQ1_READY = ready_q[1];
  assign REQ0_DONE  = done_q[0];
  assign REQ1_DONE  = done_q[1];
  assign REQ0_RDATA = rdata_q[0];
  assign REQ1_RDATA = rdata_q[1];
  assign REQ0_RESP  = resp_q[0];
  assign REQ1_RESP  = resp_q[1];

  assign axi.AXI_AWADDR  = awaddr_q;
  assign axi.AXI_AWVALID = awvalid_q;
  assign axi.AXI_WDATA   = wdata_q;
  assign axi.AXI_WVALID  = wvalid_q;
  assign axi.AXI_BREADY  = bready_q;
  assign axi.AXI_ARADDR  = araddr_q;
  assign axi.AXI_ARVALID = arvalid_q;
  assign axi.AXI_RREADY  = rready_q;

endmodule
